// File: rtl/ram_wavetable_player.sv
// rtl/ram_wavetable_player.sv - Avalon-MM wavetable reader streaming 16-bit samples to the audio DAC path
// Define WAVETABLE_LOOP_EN to honour i_loop; otherwise every playback ends through DRAIN.
module ram_wavetable_player #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_loop,
  input  logic [11:0] i_base_addr,
  input  logic [11:0] i_length,
  input  logic        i_sample_tick,
  output logic [11:0] o_m_address,
  output logic        o_m_chipselect,
  input  logic [31:0] i_m_readdata,
  output logic [15:0] o_sample_out,
  output logic        o_sample_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_underrun
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = FIFO_DEPTH[CW:0];

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t        r_state, w_next;
  logic [11:0]   r_base, r_len, r_index;
  logic          r_pend, r_half, r_done, r_underrun, r_valid;
  logic [15:0]   r_sample;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_credit, w_last_req, w_avail, w_take, w_push, w_pop, w_finish, w_loop;

`ifdef WAVETABLE_LOOP_EN
  logic r_loop;
  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_loop <= 1'b0;
    else if (r_state == S_IDLE && i_start)
      r_loop <= i_loop;
  end
  assign w_loop = r_loop;
`else
  logic w_unused_loop;
  assign w_unused_loop = i_loop;
  assign w_loop = 1'b0;
`endif

  // A read in flight already owns a FIFO slot, so credit counts it.
  assign w_credit   = ({1'b0, r_count} + {{CW{1'b0}}, r_pend}) < DEPTH_V;
  assign w_last_req = o_m_chipselect && ((r_index + 12'd1) == r_len);
  assign w_avail    = (r_count != '0);
  assign w_take     = i_sample_tick && (r_state != S_IDLE) && !i_stop;
  assign w_pop      = w_take && w_avail && r_half;
  assign w_push     = r_pend && (r_state != S_IDLE);
  assign w_finish   = (r_state == S_DRAIN) && (r_count == '0) && !r_pend && !i_stop;

  assign o_m_address    = r_base + r_index;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;
  assign o_underrun     = r_underrun;
  assign o_sample_out   = r_sample;
  assign o_sample_valid = r_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    o_m_chipselect = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start && i_length != 12'd0)
          w_next = S_FETCH;
      end
      S_FETCH: begin
        o_m_chipselect = w_credit;
        if (i_stop)
          w_next = S_IDLE;
        else if (w_last_req && !w_loop)
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (i_stop || w_finish)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= i_m_readdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_base     <= 12'd0;
      r_len      <= 12'd0;
      r_index    <= 12'd0;
      r_pend     <= 1'b0;
      r_half     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      r_valid    <= 1'b0;
      r_sample   <= 16'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_done  <= w_finish;
      r_valid <= 1'b0;
      r_pend  <= o_m_chipselect;

      if (r_state == S_IDLE && i_start) begin
        r_base     <= i_base_addr;
        r_len      <= i_length;
        r_index    <= 12'd0;
        r_underrun <= 1'b0;
        r_done     <= (i_length == 12'd0);
      end

      if (o_m_chipselect)
        r_index <= w_last_req ? 12'd0 : r_index + 12'd1;

      if (w_take) begin
        if (w_avail) begin
          r_sample <= r_half ? r_mem[r_rd_ptr][31:16] : r_mem[r_rd_ptr][15:0];
          r_valid  <= 1'b1;
          r_half   <= !r_half;
        end else begin
          r_underrun <= 1'b1;
        end
      end

      // Leaving or sitting in IDLE flushes the FIFO and drops late return data.
      if (r_state == S_IDLE || i_stop) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_half   <= 1'b0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_ram_wavetable_player.sv
// tb/tb_ram_wavetable_player.sv - directed and randomized playback checks against a table-order reference model
module tb_ram_wavetable_player;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_in = 1'b0;
  logic [11:0] base_addr = 12'd0;
  logic [11:0] length = 12'd0;
  logic        tick = 1'b0;
  logic [11:0] m_address;
  logic        m_chipselect;
  logic [31:0] m_readdata = 32'd0;
  logic [15:0] sample_out;
  logic        sample_valid, busy, done, underrun;

  logic [31:0] ram [4096];
  logic [15:0] exp_q[$], got_q[$];
  logic [11:0] expa_q[$], req_q[$];
  int          dn_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  ram_wavetable_player #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop), .i_loop(loop_in),
    .i_base_addr(base_addr), .i_length(length), .i_sample_tick(tick),
    .o_m_address(m_address), .o_m_chipselect(m_chipselect), .i_m_readdata(m_readdata),
    .o_sample_out(sample_out), .o_sample_valid(sample_valid), .o_busy(busy),
    .o_done(done), .o_underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_chipselect)
      m_readdata <= ram[m_address];
  end

  always @(negedge clk) begin
    if (sample_valid) got_q.push_back(sample_out);
    if (m_chipselect) req_q.push_back(m_address);
    if (done) dn_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    req_q.delete();
    exp_q.delete();
    expa_q.delete();
    dn_cnt = 0;
  endtask

  task automatic pulse_start(input logic [11:0] b, input logic [11:0] n, input logic lp);
    base_addr = b;
    length    = n;
    loop_in   = lp;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Non-looping playback: expected output is the table read in order, low half then high half.
  task automatic play(input logic [11:0] b, input logic [11:0] n, input logic lp,
                      input int period, input int budget);
    logic [31:0] w;
    logic [11:0] a;
    bit          seen;
    seen = 0;
    clear_obs();
    for (int i = 0; i < int'(n); i++) begin
      a = 12'(int'(b) + i);
      w = ram[a];
      expa_q.push_back(a);
      exp_q.push_back(w[15:0]);
      exp_q.push_back(w[31:16]);
    end
    pulse_start(b, n, lp);
    check("busy_with_first_req", busy, 1'b1);
    check("first_req", m_chipselect, 1'b1);
    check("underrun_cleared", underrun, 1'b0);
    for (int c = 0; c < budget && !seen; c++) begin
      tick = ((c % period) == period - 1);
      step();
      tick = 1'b0;
      if (done) begin
        seen = 1;
        check("busy_low_at_done", busy, 1'b0);
      end
    end
    check("done_timeout", seen, 1'b1);
    step();
    check("done_count", dn_cnt, 1);
    check("underrun_end", underrun, 1'b0);
    check("sample_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("sample[%0d]", i), got_q[i], exp_q[i]);
    check("req_count", req_q.size(), expa_q.size());
    for (int i = 0; i < expa_q.size() && i < req_q.size(); i++)
      check($sformatf("req_addr[%0d]", i), req_q[i], expa_q[i]);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++)
      ram[i] = $urandom;
    ram[12'h100] = 32'h0002_0001;
    ram[12'h101] = 32'h0004_0003;

    repeat (3) step();
    reset = 1'b0;
    check("rst_address", m_address, 12'd0);
    check("rst_chipselect", m_chipselect, 1'b0);
    check("rst_sample_out", sample_out, 16'd0);
    check("rst_sample_valid", sample_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_underrun", underrun, 1'b0);

    // Tick immediately after start with nothing fetched yet
    clear_obs();
    pulse_start(12'h100, 12'd2, 1'b0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("underrun_set", underrun, 1'b1);
    check("underrun_no_valid", sample_valid, 1'b0);
    check("underrun_hold", sample_out, 16'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_idle", busy, 1'b0);
    check("stop_no_done", done, 1'b0);
    repeat (4) step();
    check("stop_done_count", dn_cnt, 0);
    check("underrun_sticky", underrun, 1'b1);

    play(12'h100, 12'd2, 1'b0, 10, 200);

    ram[12'hFFF] = $urandom;
    ram[12'h000] = $urandom;
    play(12'hFFF, 12'd2, 1'b0, 4, 100);

    clear_obs();
    pulse_start(12'h123, 12'd0, 1'b0);
    check("len0_done", done, 1'b1);
    check("len0_busy", busy, 1'b0);
    step();
    check("len0_done_pulse", done, 1'b0);
    repeat (5) step();
    check("len0_no_reqs", req_q.size(), 0);
    check("len0_done_count", dn_cnt, 1);

    ram[12'h300] = 32'hBBBB_AAAA;
`ifdef WAVETABLE_LOOP_EN
    begin
      bit got6;
      got6 = 0;
      clear_obs();
      pulse_start(12'h300, 12'd1, 1'b1);
      for (int c = 0; c < 300 && !got6; c++) begin
        tick = ((c % 5) == 4);
        step();
        tick = 1'b0;
        got6 = (got_q.size() >= 6);
      end
      check("loop_samples_timeout", got6, 1'b1);
      for (int i = 0; i < 6 && i < got_q.size(); i++)
        check($sformatf("loop_sample[%0d]", i), got_q[i], (i % 2 == 0) ? 16'hAAAA : 16'hBBBB);
      check("loop_still_busy", busy, 1'b1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("loop_stop_idle", busy, 1'b0);
      repeat (4) step();
      check("loop_no_done", dn_cnt, 0);
    end
`else
    play(12'h300, 12'd1, 1'b1, 5, 100);
`endif

    clear_obs();
    pulse_start(12'h200, 12'd16, 1'b0);
    repeat (50) step();
    check("credit_reqs", req_q.size(), DEPTH);
    check("credit_busy", busy, 1'b1);
    for (int i = 0; i < DEPTH && i < req_q.size(); i++)
      check($sformatf("credit_addr[%0d]", i), req_q[i], 12'(12'h200 + i));
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();

    for (int t = 0; t < 5; t++) begin
      logic [11:0] rb, rn;
      int          rp;
      rb = 12'($urandom_range(0, 4095));
      rn = 12'($urandom_range(1, 12));
      rp = $urandom_range(3, 7);
      play(rb, rn, 1'b0, rp, int'(rn) * 2 * rp + 60);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
